// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, state encoding and DATA_W legality check.
`ifndef UART_DATA_W_OK
`define UART_DATA_W_OK(w) ((w) >= 5 && (w) <= 9)
`endif

package uart_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;
  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } par_mode_t;
endpackage

// File: rtl/uart_tx_frame_serializer_if.sv
// uart_tx_frame_serializer_if: word handshake and frame options into the Tx engine.
interface uart_tx_frame_serializer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] P_DATA;
  logic              Valid;
  logic              Ready;
  logic              Par_En;
  logic              Par_Odd;
  logic              Stop2;
  modport master(output P_DATA, Valid, Par_En, Par_Odd, Stop2, input Ready);
  modport slave(input P_DATA, Valid, Par_En, Par_Odd, Stop2, output Ready);
endinterface

// File: rtl/uart_parity_gen.sv
// uart_parity_gen: combinational even/odd parity bit over a data word.
module uart_parity_gen #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_odd,
  output logic              o_par
);
  assign o_par = ^i_data ^ i_odd;
endmodule

// File: rtl/uart_tx_frame_serializer.sv
// uart_tx_frame_serializer: UART frame transmitter (start, data LSB-first, parity, 1/2 stop).
module uart_tx_frame_serializer
  import uart_pkg::*;
#(
  parameter int   DATA_W   = 8,
  parameter logic IDLE_LVL = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  input  logic Baud_Tick,
  uart_tx_frame_serializer_if.slave s_if,
  output logic S_DATA,
  output logic Busy,
  output logic Ser_Done
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  if (!`UART_DATA_W_OK(DATA_W)) begin : g_bad_data_w
    $error("DATA_W must be in 5..9");
  end
  uart_state_t       r_state, w_state;
  logic [DATA_W-1:0] r_shift, w_shift;
  logic [CW-1:0]     r_bit_cnt, w_bit_cnt;
  logic              r_stop_cnt, w_stop_cnt;
  logic              r_par_en, w_par_en;
  logic              r_par, w_par;
  logic              r_stop2, w_stop2;
  logic              w_sdata, w_done, w_par_bit;
  uart_parity_gen #(.DATA_W(DATA_W)) u_par (
    .i_data(s_if.P_DATA),
    .i_odd (s_if.Par_Odd),
    .o_par (w_par_bit)
  );
  assign s_if.Ready = (r_state == ST_IDLE);
  assign Busy       = (r_state != ST_IDLE);
  always_comb begin
    w_state    = r_state;
    w_shift    = r_shift;
    w_bit_cnt  = r_bit_cnt;
    w_stop_cnt = r_stop_cnt;
    w_par_en   = r_par_en;
    w_par      = r_par;
    w_stop2    = r_stop2;
    w_sdata    = S_DATA;
    w_done     = 1'b0;
    case (r_state)
      ST_IDLE: if (s_if.Valid) begin
        w_state  = ST_WAIT;
        w_shift  = s_if.P_DATA;
        w_par_en = s_if.Par_En;
        w_par    = w_par_bit;
        w_stop2  = s_if.Stop2;
      end
      ST_WAIT: if (Baud_Tick) begin
        w_state = ST_START;
        w_sdata = ~IDLE_LVL;
      end
      ST_START: if (Baud_Tick) begin
        w_state   = ST_DATA;
        w_sdata   = r_shift[0];
        w_shift   = r_shift >> 1;
        w_bit_cnt = '0;
      end
      ST_DATA: if (Baud_Tick) begin
        if (r_bit_cnt == LAST) begin
          w_state    = r_par_en ? ST_PARITY : ST_STOP;
          w_sdata    = r_par_en ? r_par : IDLE_LVL;
          w_stop_cnt = 1'b0;
        end else begin
          w_bit_cnt = r_bit_cnt + 1'b1;
          w_sdata   = r_shift[0];
          w_shift   = r_shift >> 1;
        end
      end
      ST_PARITY: if (Baud_Tick) begin
        w_state    = ST_STOP;
        w_sdata    = IDLE_LVL;
        w_stop_cnt = 1'b0;
      end
      // second stop period only when the latched Stop2 asked for it
      ST_STOP: if (Baud_Tick) begin
        if (r_stop2 && !r_stop_cnt) begin
          w_stop_cnt = 1'b1;
        end else begin
          w_state = ST_IDLE;
          w_done  = 1'b1;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_par_en   <= 1'b0;
      r_par      <= 1'b0;
      r_stop2    <= 1'b0;
      S_DATA     <= IDLE_LVL;
      Ser_Done   <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_shift    <= w_shift;
      r_bit_cnt  <= w_bit_cnt;
      r_stop_cnt <= w_stop_cnt;
      r_par_en   <= w_par_en;
      r_par      <= w_par;
      r_stop2    <= w_stop2;
      S_DATA     <= w_sdata;
      Ser_Done   <= w_done;
    end
  end
endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// tb_uart_tx_frame_serializer: scoreboard bench for 8-bit and 5-bit Tx engines.
module tb_uart_tx_frame_serializer;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic tick = 1'b0;
  int   tick_cnt = 0;
  int   tests = 0;
  int   fails = 0;
  logic sd8, b8, d8, sd5, b5, d5;
  logic [1:0] sd_w, busy_w, done_w, rdy_w;
  string expq[2][$];
  string cur[2];
  bit    col[2];
  uart_tx_frame_serializer_if #(.DATA_W(8)) if8 ();
  uart_tx_frame_serializer_if #(.DATA_W(5)) if5 ();
  uart_tx_frame_serializer #(.DATA_W(8)) u8 (
    .CLK(CLK), .RST(RST), .Baud_Tick(tick), .s_if(if8),
    .S_DATA(sd8), .Busy(b8), .Ser_Done(d8)
  );
  uart_tx_frame_serializer #(.DATA_W(5)) u5 (
    .CLK(CLK), .RST(RST), .Baud_Tick(tick), .s_if(if5),
    .S_DATA(sd5), .Busy(b5), .Ser_Done(d5)
  );
  assign sd_w   = {sd5, sd8};
  assign busy_w = {b5, b8};
  assign done_w = {d5, d8};
  assign rdy_w  = {if5.Ready, if8.Ready};
  always #5 CLK = ~CLK;
  // one-cycle baud tick every 5 clocks, set up on the falling edge
  always @(negedge CLK) begin
    tick_cnt = (tick_cnt == 4) ? 0 : tick_cnt + 1;
    tick = (tick_cnt == 4);
  end
  always begin
    logic st, sr;
    string e;
    @(posedge CLK);
    st = tick;
    sr = RST;
    @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      if (!sr) begin
        col[i] = 1'b0;
        cur[i] = "";
      end else if (done_w[i] === 1'b1) begin
        tests++;
        if (expq[i].size() == 0) begin
          fails++;
          $display("FAIL frame%0d: unexpected Ser_Done, line got %s", i, cur[i]);
        end else begin
          e = expq[i].pop_front();
          if (cur[i] != e) begin
            fails++;
            $display("FAIL frame%0d: line got %s want %s", i, cur[i], e);
          end
        end
        tests++;
        if (!(rdy_w[i] === 1'b1 && busy_w[i] === 1'b0)) begin
          fails++;
          $display("FAIL done_state%0d: ready=%b busy=%b want ready=1 busy=0", i, rdy_w[i], busy_w[i]);
        end
        col[i] = 1'b0;
        cur[i] = "";
      end else if (st && busy_w[i] === 1'b1 && (col[i] || sd_w[i] === 1'b0)) begin
        col[i] = 1'b1;
        cur[i] = {cur[i], (sd_w[i] === 1'b1) ? "1" : "0"};
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask
  task automatic wait_done(input int i);
    int k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (done_w[i] !== 1'b1 && k < 400);
    if (done_w[i] !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL timeout%0d: Ser_Done got 0 want 1 within 400 cycles", i);
    end
  endtask
  task automatic send8(input logic [7:0] d, input logic pe, input logic po, input logic s2, input string e);
    expq[0].push_back(e);
    @(negedge CLK);
    if8.P_DATA = d;
    if8.Par_En = pe;
    if8.Par_Odd = po;
    if8.Stop2 = s2;
    if8.Valid = 1'b1;
    @(negedge CLK);
    if8.Valid = 1'b0;
    wait_done(0);
  endtask
  initial begin
    int k, n;
    if8.P_DATA = '0; if8.Valid = 1'b0; if8.Par_En = 1'b0; if8.Par_Odd = 1'b0; if8.Stop2 = 1'b0;
    if5.P_DATA = '0; if5.Valid = 1'b0; if5.Par_En = 1'b0; if5.Par_Odd = 1'b0; if5.Stop2 = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_sdata8", 32'(sd8), 1);
    chk("rst_ready8", 32'(if8.Ready), 1);
    chk("rst_busy8", 32'(b8), 0);
    chk("rst_done8", 32'(d8), 0);
    chk("rst_sdata5", 32'(sd5), 1);
    chk("rst_ready5", 32'(if5.Ready), 1);
    chk("rst_busy5", 32'(b5), 0);
    chk("rst_done5", 32'(d5), 0);
    RST = 1'b1;
    send8(8'hA5, 1'b0, 1'b0, 1'b0, "0101001011");
    send8(8'hA5, 1'b1, 1'b0, 1'b1, "010100101011");
    send8(8'hA5, 1'b1, 1'b1, 1'b0, "01010010111");
    expq[1].push_back("01111111");
    expq[1].push_back("01111111");
    @(negedge CLK);
    if5.P_DATA = 5'h1F; if5.Par_En = 1'b1; if5.Par_Odd = 1'b0; if5.Stop2 = 1'b0; if5.Valid = 1'b1;
    wait_done(1);
    chk("b2b_ready", 32'(if5.Ready), 1);
    k = 0;
    do begin
      @(negedge CLK);
      k++;
      if (k == 1) begin
        chk("b2b_accept", 32'(b5), 1);
        if5.Valid = 1'b0;
      end
    end while (sd5 !== 1'b0 && k < 50);
    chk("b2b_gap", 32'(k), 5);
    wait_done(1);
    @(negedge CLK);
    if8.P_DATA = 8'h00; if8.Par_En = 1'b0; if8.Stop2 = 1'b0; if8.Valid = 1'b1;
    @(negedge CLK);
    if8.Valid = 1'b0;
    k = 0;
    while (sd8 !== 1'b0 && k < 100) begin
      @(negedge CLK);
      k++;
    end
    n = 0;
    k = 0;
    while (n < 4 && k < 100) begin
      @(posedge CLK);
      k++;
      if (tick) n++;
    end
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("midrst_sdata", 32'(sd8), 1);
    chk("midrst_ready", 32'(if8.Ready), 1);
    chk("midrst_busy", 32'(b8), 0);
    RST = 1'b1;
    send8(8'h3C, 1'b0, 1'b0, 1'b0, "0001111001");
    k = 0;
    do begin
      @(negedge CLK);
      #1;
      k++;
    end while (!tick && k < 20);
    expq[0].push_back("01010010101");
    if8.P_DATA = 8'hA5; if8.Par_En = 1'b1; if8.Par_Odd = 1'b0; if8.Stop2 = 1'b0; if8.Valid = 1'b1;
    @(negedge CLK);
    chk("coin_busy", 32'(b8), 1);
    chk("coin_wait_line", 32'(sd8), 1);
    if8.P_DATA = 8'h00; if8.Par_Odd = 1'b1; if8.Stop2 = 1'b1; if8.Par_En = 1'b0; if8.Valid = 1'b0;
    k = 0;
    while (sd8 !== 1'b0 && k < 50) begin
      @(negedge CLK);
      k++;
    end
    chk("coin_gap", 32'(k), 5);
    wait_done(0);
    repeat (3) @(negedge CLK);
    chk("q8_empty", 32'(expq[0].size()), 0);
    chk("q5_empty", 32'(expq[1].size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
